mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Data-memory access stage downstream of the single-cycle datapath. Consumes address, store data,
//  access size and sign from the core. Drives a word-wide, byte-enabled, wait-state data bus.
//  Splits misaligned accesses into two bus beats and returns sign/zero-extended load data.
//  Holds the core via stall until each access completes or times out.
// PARAMETERS
//  TIMEOUT_CYC  16  max cycles bus_req may stay high without bus_ack before err (>=2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  req_valid  in   1   core requests memory op; held stable until rsp_valid
//  req_we     in   1   1=store, 0=load
//  req_addr   in   32  byte address (any alignment)
//  req_wdata  in   32  store data, LSB-justified
//  req_size   in   2   00=byte, 01=half, 10=word, 11=illegal (treated as word)
//  req_sign   in   1   load sign-extend enable (ignored for word/store)
//  req_ready  out  1   1 only in IDLE
//  stall      out  1   req_valid & ~rsp_valid (combinational)
//  rsp_valid  out  1   one-cycle pulse at completion (load or store)
//  rsp_rdata  out  32  extended load data, valid with rsp_valid; 0 for stores/err
//  err        out  1   one-cycle pulse with rsp_valid on timeout
//  bus_req    out  1   bus request, held until ack
//  bus_we     out  1   bus write
//  bus_addr   out  32  word address, bits[1:0]=00
//  bus_be     out  4   byte-lane enables
//  bus_wdata  out  32  lane-aligned write data
//  bus_rdata  in   32  read data, valid in ack cycle
//  bus_ack    in   1   single-cycle beat completion
// BEHAVIOUR
//  Reset: state=IDLE; bus_req/bus_we/bus_be/bus_wdata/bus_addr, rsp_valid, rsp_rdata, err, timer = 0.
//  rst mid-access aborts immediately: bus_req falls asynchronously, response lost, no err.
//  FSM: IDLE -> BEAT0 -> (BEAT1) -> DONE -> IDLE.
//  IDLE: on req_valid, latch request: off=addr[1:0], n=1/2/4 bytes, mask=(1<<n)-1; go BEAT0.
//  split = (off+n > 4). BEAT0: addr=addr&~3, be=mask<<off, wdata=wdata<<(8*off).
//  BEAT1 (only if split): addr=(addr&~3)+4 (mod 2^32), be=mask>>(4-off),
//  wdata=wdata>>(8*(4-off)).
//  Beat handshake: bus_req and fields are registered, stable while waiting. Beat ends in the
//  cycle bus_ack=1. BEAT0 ack -> BEAT1 if split, else DONE. BEAT1 ack -> DONE.
//  bus_ack while bus_req=0 is ignored.
//  Load assembly: BEAT0 captures rdata>>(8*off). BEAT1 ORs rdata<<(8*(4-off)) into upper bytes.
//  Result truncated to n bytes, then sign-extended if req_sign & size!=word, else zero-extended.
//  DONE: bus_req=0, rsp_valid=1, rsp_rdata=result for one cycle, then IDLE.
//  A new req accepted in DONE is not allowed (req_ready=0); it is accepted next cycle.
//  Latency without wait states: aligned = 3 cycles accept->rsp_valid; split = 4.
//  Each extra wait cycle adds 1.
//  Timeout: timer clears at beat start and counts cycles bus_req=1 && !bus_ack.
//  At TIMEOUT_CYC -> DONE with err=1, rsp_rdata=0, remaining beat skipped. BEAT0 stores
//  already acked stay written.
//  Request fields sampled only at accept; changes afterwards are ignored.
// TESTING
//  1 sw addr=0x100 data=0xDEADBEEF, ack after 0 waits -> 1 beat addr 0x100 be=1111,
//    rsp_valid 3 cycles after accept.
//  2 sb addr=0x103 data=0x000000AB -> be=1000, bus_wdata=0xAB000000, single beat.
//  3 lh addr=0x203, sign=1, mem[0x200]=0x80xxxxxx, mem[0x204]=0xxxxxxxFF ->
//    beats 0x200 be=1000 then 0x204 be=0001, rsp_rdata=0xFFFFFF80.
//  4 lb addr=0x10 mem=0x00000080: sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080;
//    3 wait cycles -> stall held 6 cycles.
//  5 lw, bus_ack never asserted -> err & rsp_valid pulse exactly TIMEOUT_CYC cycles after bus_req
//    rises; rdata=0; back to IDLE.
//  6 sw addr=0x1FE (split), assert rst during BEAT1 wait -> bus_req=0 same cycle, state IDLE,
//    no rsp_valid, next request served normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and word-wide data-bus signals of the memory access stage.
// slave = the access unit's view, master = the core/memory environment's view.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign, bus_rdata, bus_ack,
    output req_ready, stall, rsp_valid, rsp_rdata, err,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_sign, bus_rdata, bus_ack,
    input  req_ready, stall, rsp_valid, rsp_rdata, err,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access stage: splits misaligned byte/half/word accesses into up to two
// byte-enabled bus beats, assembles and extends load data, and times out stuck beats.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave mif
);
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] base, base_n;
  logic [1:0]  off, off_n;
  logic [1:0]  size, size_n;
  logic        sign, sign_n;
  logic        we, we_n;
  logic [31:0] wdata, wdata_n;
  logic [31:0] acc, acc_n;
  logic [TW-1:0] timer, timer_n;
  logic        bus_req_q, bus_req_n;
  logic        bus_we_q, bus_we_n;
  logic [31:0] bus_addr_q, bus_addr_n;
  logic [3:0]  bus_be_q, bus_be_n;
  logic [31:0] bus_wdata_q, bus_wdata_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [31:0] rsp_rdata_q, rsp_rdata_n;
  logic        err_q, err_n;

  logic [3:0]  mask;
  logic        split;
  logic [4:0]  sh;
  logic [7:0]  be_pair;
  logic [63:0] wd_pair;
  logic [31:0] lo, hi, merged, ext;
  logic        fin, tmo;

  // Both beats come out of one double-width shift: the low half is beat 0, the high half beat 1.
  assign sh      = {off, 3'b000};
  assign be_pair = {4'b0000, mask} << off;
  assign wd_pair = {32'h0, wdata} << sh;
  assign lo      = mif.bus_rdata >> sh;
  assign hi      = mif.bus_rdata << (6'd32 - {1'b0, sh});
  assign merged  = (state == BEAT1) ? (acc | hi) : lo;

  always_comb begin
    mask  = 4'b1111;
    split = (off != 2'd0);
    ext   = merged;
    unique case (size)
      2'b00: begin
        mask  = 4'b0001;
        split = 1'b0;
        ext   = sign ? {{24{merged[7]}}, merged[7:0]} : {24'h0, merged[7:0]};
      end
      2'b01: begin
        mask  = 4'b0011;
        split = (off == 2'd3);
        ext   = sign ? {{16{merged[15]}}, merged[15:0]} : {16'h0, merged[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    base_n      = base;
    off_n       = off;
    size_n      = size;
    sign_n      = sign;
    we_n        = we;
    wdata_n     = wdata;
    acc_n       = acc;
    timer_n     = timer;
    bus_req_n   = bus_req_q;
    bus_we_n    = bus_we_q;
    bus_addr_n  = bus_addr_q;
    bus_be_n    = bus_be_q;
    bus_wdata_n = bus_wdata_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = '0;
    err_n       = 1'b0;
    fin         = 1'b0;
    tmo         = 1'b0;
    unique case (state)
      IDLE: begin
        if (mif.req_valid) begin
          base_n  = {mif.req_addr[31:2], 2'b00};
          off_n   = mif.req_addr[1:0];
          size_n  = mif.req_size;
          sign_n  = mif.req_sign;
          we_n    = mif.req_we;
          wdata_n = mif.req_wdata;
          state_n = BEAT0;
        end
      end
      BEAT0: begin
        // First BEAT0 cycle registers the beat fields; later cycles wait for ack.
        if (!bus_req_q) begin
          bus_req_n   = 1'b1;
          bus_we_n    = we;
          bus_addr_n  = base;
          bus_be_n    = be_pair[3:0];
          bus_wdata_n = wd_pair[31:0];
          timer_n     = '0;
        end else if (mif.bus_ack) begin
          if (split) begin
            acc_n       = lo;
            state_n     = BEAT1;
            bus_addr_n  = base + 32'd4;
            bus_be_n    = be_pair[7:4];
            bus_wdata_n = wd_pair[63:32];
            timer_n     = '0;
          end else begin
            fin = 1'b1;
          end
        end else if (timer == TLAST) begin
          tmo = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      BEAT1: begin
        if (mif.bus_ack) begin
          fin = 1'b1;
        end else if (timer == TLAST) begin
          tmo = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (fin || tmo) begin
      state_n     = DONE;
      bus_req_n   = 1'b0;
      bus_we_n    = 1'b0;
      bus_addr_n  = '0;
      bus_be_n    = '0;
      bus_wdata_n = '0;
      rsp_valid_n = 1'b1;
      err_n       = tmo;
      rsp_rdata_n = (tmo || we) ? '0 : ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      off         <= '0;
      size        <= '0;
      sign        <= 1'b0;
      we          <= 1'b0;
      wdata       <= '0;
      acc         <= '0;
      timer       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      base        <= base_n;
      off         <= off_n;
      size        <= size_n;
      sign        <= sign_n;
      we          <= we_n;
      wdata       <= wdata_n;
      acc         <= acc_n;
      timer       <= timer_n;
      bus_req_q   <= bus_req_n;
      bus_we_q    <= bus_we_n;
      bus_addr_q  <= bus_addr_n;
      bus_be_q    <= bus_be_n;
      bus_wdata_q <= bus_wdata_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      err_q       <= err_n;
    end
  end

  assign mif.req_ready = (state == IDLE);
  assign mif.stall     = mif.req_valid & ~rsp_valid_q;
  assign mif.rsp_valid = rsp_valid_q;
  assign mif.rsp_rdata = rsp_rdata_q;
  assign mif.err       = err_q;
  assign mif.bus_req   = bus_req_q;
  assign mif.bus_we    = bus_we_q;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_be    = bus_be_q;
  assign mif.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed memory responder with wait states, a table of
// accesses checked through beat/response scoreboards, plus timeout and mid-access reset.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_access_unit_if mif();

  mem_access_unit #(.TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    int unsigned waits;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  beat_t exp_beats[$];
  rsp_t  exp_rsp[$];
  logic [7:0] mem [logic [31:0]];
  int unsigned waits = 0;
  int unsigned ack_budget = 1000;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rdb(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h5A ^ a[7:0];
  endfunction

  function automatic logic [31:0] rdw(input logic [31:0] a);
    return {rdb(a + 32'd3), rdb(a + 32'd2), rdb(a + 32'd1), rdb(a)};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + 32'(k)] = w[8*k +: 8];
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Expected beats derived byte by byte: which lanes of which word the access touches.
  task automatic push_beats(input logic we, input logic [31:0] a, input logic [31:0] wd, input int n);
    beat_t b;
    int off;
    off = int'(a[1:0]);
    b.addr = {a[31:2], 2'b00}; b.we = we; b.be = '0; b.wdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (k >= off && k < off + n) b.be[k] = 1'b1;
      if (k >= off) b.wdata[8*k +: 8] = wd[8*(k-off) +: 8];
    end
    exp_beats.push_back(b);
    if (off + n > 4) begin
      b.addr = {a[31:2], 2'b00} + 32'd4; b.be = '0; b.wdata = '0;
      for (int k = 0; k < 4; k++) begin
        if (k + 4 < off + n) b.be[k] = 1'b1;
        if (k < off) b.wdata[8*k +: 8] = wd[8*(k+4-off) +: 8];
      end
      exp_beats.push_back(b);
    end
  endtask

  // Memory responder: ack after `waits` cycles of each beat, at most ack_budget acks.
  initial begin
    int unsigned wcnt;
    wcnt = 0;
    mif.bus_ack = 1'b0;
    mif.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mif.bus_req) begin
        mif.bus_ack = 1'b0;
        wcnt = 0;
      end else begin
        if (mif.bus_ack) wcnt = 0;
        if (ack_budget > 0 && wcnt == waits) begin
          mif.bus_ack = 1'b1;
          mif.bus_rdata = rdw(mif.bus_addr);
          ack_budget--;
        end else begin
          mif.bus_ack = 1'b0;
          mif.bus_rdata = $urandom;
        end
        wcnt++;
      end
    end
  end

  // Monitor: compares each acked beat and each response against the scoreboards.
  initial begin
    beat_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst && mif.bus_req && mif.bus_ack) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", mif.bus_addr, 32'hFFFF_FFFF);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_addr", mif.bus_addr, b.addr);
          chk("beat_be", 32'(mif.bus_be), 32'(b.be));
          chk("beat_we", 32'(mif.bus_we), 32'(b.we));
          if (b.we) chk("beat_wdata", mif.bus_wdata, b.wdata);
        end
        if (mif.bus_we)
          for (int k = 0; k < 4; k++)
            if (mif.bus_be[k]) mem[mif.bus_addr + 32'(k)] = mif.bus_wdata[8*k +: 8];
      end
      if (!rst && mif.rsp_valid) begin
        chk("beats_outstanding", 32'(exp_beats.size()), 32'd0);
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", mif.rsp_rdata, 32'hFFFF_FFFF);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata", mif.rsp_rdata, r.rdata);
          chk("rsp_err", 32'(mif.err), 32'(r.err));
        end
      end
    end
  end

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] s, input logic sg);
    mif.req_valid = 1'b1;
    mif.req_we    = we;
    mif.req_addr  = a;
    mif.req_wdata = wd;
    mif.req_size  = s;
    mif.req_sign  = sg;
  endtask

  task automatic run_op(input vec_t v);
    int unsigned cyc, stalls;
    rsp_t r;
    waits = v.waits;
    push_beats(v.we, v.addr, v.wdata, nbytes(v.size));
    r.rdata = v.we ? 32'h0 : v.exp_rdata;
    r.err = 1'b0;
    exp_rsp.push_back(r);
    @(negedge clk);
    chk("req_ready_idle", 32'(mif.req_ready), 32'd1);
    drive_req(v.we, v.addr, v.wdata, v.size, v.sign);
    #1;
    stalls = mif.stall ? 1 : 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // request already latched; later field changes must have no effect
        mif.req_addr = $urandom; mif.req_wdata = $urandom;
        mif.req_size = 2'($urandom); mif.req_sign = ~mif.req_sign; mif.req_we = ~mif.req_we;
      end
      if (mif.stall) stalls++;
      if (mif.rsp_valid || cyc >= 60) break;
    end
    chk("rsp_seen", 32'(mif.rsp_valid), 32'd1);
    chk("latency", cyc, v.exp_lat);
    chk("stall_cycles", stalls, v.exp_lat);
    chk("req_ready_done", 32'(mif.req_ready), 32'd0);
    mif.req_valid = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    logic found;
    rsp_t r;
    beat_t dropped;
    mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_addr = '0;
    mif.req_wdata = '0; mif.req_size = '0; mif.req_sign = 1'b0;
    set_word(32'h200, 32'h8011_2233);
    set_word(32'h204, 32'h4455_66FF);
    set_word(32'h010, 32'h0000_0080);
    set_word(32'h1FC, 32'hCAFE_F00D);
    set_word(32'hFFFF_FFFC, 32'h0102_0304);
    set_word(32'h000, 32'hA0B0_C0D0);

    //          we    addr          wdata          sz     sg   w  exp_rdata      lat
    vecs.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 32'h0,          3});
    vecs.push_back('{1'b1, 32'h103, 32'h0000_00AB, 2'b00, 1'b0, 0, 32'h0,          3});
    vecs.push_back('{1'b0, 32'h203, 32'h0,         2'b01, 1'b1, 0, 32'hFFFF_FF80, 4});
    vecs.push_back('{1'b0, 32'h010, 32'h0,         2'b00, 1'b1, 0, 32'hFFFF_FF80, 3});
    vecs.push_back('{1'b0, 32'h010, 32'h0,         2'b00, 1'b0, 0, 32'h0000_0080, 3});
    vecs.push_back('{1'b0, 32'h010, 32'h0,         2'b00, 1'b1, 3, 32'hFFFF_FF80, 6});
    vecs.push_back('{1'b0, 32'h100, 32'h0,         2'b10, 1'b1, 0, 32'hABAD_BEEF, 3});
    vecs.push_back('{1'b0, 32'h202, 32'h0,         2'b01, 1'b0, 0, 32'h0000_8011, 3});
    vecs.push_back('{1'b0, 32'h1FD, 32'h0,         2'b10, 1'b0, 0, 32'h33CA_FEF0, 4});
    vecs.push_back('{1'b1, 32'h1FE, 32'h1234_5678, 2'b10, 1'b0, 1, 32'h0,          6});
    vecs.push_back('{1'b0, 32'h1FC, 32'h0,         2'b10, 1'b0, 0, 32'h5678_F00D, 3});
    vecs.push_back('{1'b0, 32'h200, 32'h0,         2'b01, 1'b1, 0, 32'h0000_1234, 3});
    vecs.push_back('{1'b0, 32'h204, 32'h0,         2'b11, 1'b1, 0, 32'h4455_66FF, 3});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0,   2'b01, 1'b1, 0, 32'hFFFF_D001, 4});
    vecs.push_back('{1'b1, 32'h101, 32'hFFFF_FF11, 2'b00, 1'b0, 2, 32'h0,          5});
    vecs.push_back('{1'b0, 32'h100, 32'h0,         2'b10, 1'b0, 0, 32'hABAD_11EF, 3});
    vecs.push_back('{1'b0, 32'h203, 32'h0,         2'b00, 1'b1, 0, 32'hFFFF_FF80, 3});

    #1;
    rst = 1'b1;
    #2;
    chk("rst_bus_req", 32'(mif.bus_req), 32'd0);
    chk("rst_bus_addr", mif.bus_addr, 32'h0);
    chk("rst_bus_be", 32'(mif.bus_be), 32'd0);
    chk("rst_rsp_valid", 32'(mif.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", mif.rsp_rdata, 32'h0);
    chk("rst_err", 32'(mif.err), 32'd0);
    chk("rst_req_ready", 32'(mif.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Timeout: bus never acks; err with rsp_valid exactly 16 cycles after bus_req rises.
    ack_budget = 0;
    r.rdata = 32'h0; r.err = 1'b1;
    exp_rsp.push_back(r);
    @(negedge clk);
    drive_req(1'b0, 32'h300, 32'h0, 2'b10, 1'b0);
    cnt = 0;
    while (!mif.bus_req && cnt < 10) begin @(negedge clk); cnt++; end
    chk("tmo_bus_req_rise", 32'(mif.bus_req), 32'd1);
    cnt = 0;
    found = 1'b1;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (mif.rsp_valid || cnt >= 40) break;
      if (!mif.bus_req) found = 1'b0;
    end
    chk("tmo_req_held", 32'(found), 32'd1);
    chk("tmo_latency", cnt, 32'd16);
    chk("tmo_bus_req_low", 32'(mif.bus_req), 32'd0);
    mif.req_valid = 1'b0;
    @(negedge clk);
    chk("tmo_back_idle", 32'(mif.req_ready), 32'd1);

    // Reset during the second beat of a split store: only beat 0 reaches memory.
    ack_budget = 1;
    waits = 0;
    push_beats(1'b1, 32'h1FE, 32'hA1B2_C3D4, 4);
    dropped = exp_beats.pop_back();
    drive_req(1'b1, 32'h1FE, 32'hA1B2_C3D4, 2'b10, 1'b0);
    cnt = 0;
    found = 1'b0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (mif.bus_req && mif.bus_addr == dropped.addr) begin found = 1'b1; break; end
    end
    chk("rst_test_beat1_reached", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_bus_req", 32'(mif.bus_req), 32'd0);
    chk("midrst_idle", 32'(mif.req_ready), 32'd1);
    chk("midrst_no_rsp", 32'(mif.rsp_valid), 32'd0);
    @(negedge clk);
    mif.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_beats_left", 32'(exp_beats.size()), 32'd0);
    chk("midrst_rsp_left", 32'(exp_rsp.size()), 32'd0);
    ack_budget = 1000;
    run_op('{1'b0, 32'h1FE, 32'h0, 2'b10, 1'b0, 0, 32'h1234_C3D4, 4});

    repeat (3) @(negedge clk);
    chk("final_rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1);
  end
endmodule
